pipe_mem_arbiter: RTL and testbench

- Sequences a single shared memory port between the pipeline's instruction-fetch (IF) and data-memory (MEM) stages.
- Arbitrates between them: MEM has priority, with a starvation guard for IF.
- Drives the memory handshake and returns read data with a one-cycle done pulse.
- Generates stall signals for the pipeline while a stage's access is outstanding.

---
 rtl/pipe_mem_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_pipe_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pipe_mem_arbiter
//
// Shares one memory port between the instruction-fetch (IF) stage and the
// data-memory (MEM) stage of the pipeline. MEM normally wins. After
// STREAK_MAX back-to-back MEM grants taken while IF was waiting, the next
// contended grant goes to IF.
//
// Sequence of one access: IDLE (grant) -> BUS_I/BUS_D (mem_req high until
// mem_ack) -> RESP (one-cycle done pulse) -> IDLE.
//
// Optional build macro: ARB_TIMEOUT_EN
//   When defined, a bus access that sees no mem_ack for TIMEOUT cycles is
//   aborted. The stage still gets its done pulse, with read data forced to 0,
//   and the sticky err flag is set. When undefined, a bus access waits
//   indefinitely and err is constant 0.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   if_req     in   fetch request, held with if_addr until if_done
//   if_addr    in   fetch address
//   if_rdata   out  fetched instruction, valid while if_done=1
//   if_done    out  one-cycle fetch completion pulse
//   d_req      in   data request, held with its command until d_done
//   d_we       in   1 = write, 0 = read
//   d_addr     in   data address
//   d_wdata    in   write data
//   d_be       in   byte enables
//   d_rdata    out  load data, valid while d_done=1 on reads
//   d_done     out  one-cycle data completion pulse
//   mem_req    out  registered memory request
//   mem_we     out  registered write strobe
//   mem_addr   out  registered address
//   mem_wdata  out  registered write data
//   mem_be     out  registered byte enables
//   mem_ack    in   memory completion, mem_rdata valid in the same cycle
//   mem_rdata  in   memory read data
//   stall_if   out  if_req & ~if_done
//   stall_mem  out  d_req & ~d_done
//   err        out  sticky timeout flag
// -----------------------------------------------------------------------------
module pipe_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STREAK_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall_if,
    output logic                  stall_mem,
    output logic                  err
);

    localparam int BE_W     = DATA_W / 8;
    localparam int STREAK_W = $clog2(STREAK_MAX + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUS_I = 2'd1;
    localparam logic [1:0] ST_BUS_D = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [STREAK_W-1:0] STREAK_LIM  = STREAK_W'(STREAK_MAX);
    localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(1);
    localparam logic [STREAK_W-1:0] STREAK_ZERO = {STREAK_W{1'b0}};

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    // Last waiting cycle: reaching it without an ack means the count hits TIMEOUT.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [TO_W-1:0] wait_cnt_r;
`endif

    logic [1:0]          state_r;
    logic [STREAK_W-1:0] streak_r;
    logic                grant_d_s;
    logic                grant_i_s;
    logic [STREAK_W-1:0] streak_nxt_s;

    // Arbitration in IDLE: MEM wins unless IF has been passed over STREAK_MAX times.
    always_comb begin
        grant_d_s    = 1'b0;
        grant_i_s    = 1'b0;
        streak_nxt_s = streak_r;
        if (state_r == ST_IDLE) begin
            if (d_req && !(if_req && (streak_r == STREAK_LIM))) begin
                grant_d_s = 1'b1;
                if (if_req) begin
                    if (streak_r == STREAK_LIM) begin
                        streak_nxt_s = streak_r;
                    end else begin
                        streak_nxt_s = streak_r + STREAK_ONE;
                    end
                end else begin
                    streak_nxt_s = STREAK_ZERO;
                end
            end else if (if_req) begin
                grant_i_s    = 1'b1;
                streak_nxt_s = STREAK_ZERO;
            end else begin
                streak_nxt_s = streak_r;
            end
        end else begin
            streak_nxt_s = streak_r;
        end
    end

    // Stalls depend only on the request levels and the registered done pulses.
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = d_req  & ~d_done;

`ifndef ARB_TIMEOUT_EN
    assign err = 1'b0;
`endif

    // Access sequencer: grant, registered memory command, response capture, done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            streak_r  <= STREAK_ZERO;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            mem_be    <= {BE_W{1'b0}};
            if_rdata  <= {DATA_W{1'b0}};
            d_rdata   <= {DATA_W{1'b0}};
            if_done   <= 1'b0;
            d_done    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wait_cnt_r <= {TO_W{1'b0}};
            err        <= 1'b0;
`endif
        end else begin
            // Done pulses last exactly one cycle (the RESP cycle).
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    streak_r <= streak_nxt_s;
`ifdef ARB_TIMEOUT_EN
                    wait_cnt_r <= {TO_W{1'b0}};
`endif
                    if (grant_d_s) begin
                        state_r   <= ST_BUS_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                    end else if (grant_i_s) begin
                        // Fetches are full-word reads.
                        state_r   <= ST_BUS_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= {DATA_W{1'b0}};
                        mem_be    <= {BE_W{1'b1}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUS_I, ST_BUS_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_r <= ST_RESP;
                        if (state_r == ST_BUS_I) begin
                            if_rdata <= mem_rdata;
                            if_done  <= 1'b1;
                        end else begin
                            d_done <= 1'b1;
                            // Writes leave the last load value in place.
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                d_rdata <= d_rdata;
                            end
                        end
`ifdef ARB_TIMEOUT_EN
                    end else if (wait_cnt_r == TO_LAST) begin
                        // Abort: complete the access with zero data (a NOP for fetch).
                        mem_req <= 1'b0;
                        state_r <= ST_RESP;
                        err     <= 1'b1;
                        if (state_r == ST_BUS_I) begin
                            if_rdata <= {DATA_W{1'b0}};
                            if_done  <= 1'b1;
                        end else begin
                            d_done <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= {DATA_W{1'b0}};
                            end else begin
                                d_rdata <= d_rdata;
                            end
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TO_ONE;
                    end
`else
                    end else begin
                        state_r <= state_r;
                    end
`endif
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pipe_mem_arbiter
//
// Self-checking bench for pipe_mem_arbiter. The bench acts as the memory
// (fixed read pattern, programmable ack delay). Each expected completion is
// queued when its request is driven and popped when a done pulse appears.
// -----------------------------------------------------------------------------
module tb_pipe_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    pipe_mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          ack_wait = 0;
    logic        ack_en = 1'b0;
    logic [31:0] last_d = 32'h0000_0000;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Bench memory contents.
    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2008_0005;
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory responder: ack after ack_wait bus cycles, one cycle wide.
    initial begin
        int wcnt;
        wcnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0000_0000;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req && ack_en) begin
                if (wcnt == ack_wait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd_model(mem_addr);
                    wcnt      = 0;
                end else begin
                    wcnt = wcnt + 1;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && (if_done || d_done)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", {30'd0, d_done, if_done}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_kind", {31'd0, d_done}, {31'd0, e.is_d});
                chk("done_both", {31'd0, if_done & d_done}, 32'd0);
                chk("rdata", d_done ? d_rdata : if_rdata, e.rdata);
            end
        end
    end

    task automatic push(input logic is_d, input logic [31:0] rdata);
        exp_t e;
        e.is_d  = is_d;
        e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    // Wait (bounded) until every queued access has completed.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n = n + 1;
        end
        chk("drain_timeout", sb_q.size(), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Both requesters held; access k finishes in cycle 3k+2, every 5th is IF.
    task automatic run_contention(input int n_acc);
        ack_wait = 0;
        ack_en   = 1'b1;
        d_we     = 1'b0;
        d_addr   = 32'h0000_0100;
        d_be     = 4'hF;
        if_addr  = 32'h0000_0200;
        for (int k = 0; k < n_acc; k++) begin
            if ((k % 5) == 4) push(1'b0, rd_model(32'h0000_0200));
            else push(1'b1, rd_model(32'h0000_0100));
        end
        @(negedge clk);
        if_req = 1'b1;
        d_req  = 1'b1;
        for (int c = 0; c < 3 * n_acc; c++) begin
            logic if_dc;
            logic d_dc;
            if (c != 0) @(negedge clk);
            #1;
            if_dc = ((c % 3) == 2) && (((c / 3) % 5) == 4);
            d_dc  = ((c % 3) == 2) && (((c / 3) % 5) != 4);
            chk("stall_if", {31'd0, stall_if}, {31'd0, ~if_dc});
            chk("stall_mem", {31'd0, stall_mem}, {31'd0, ~d_dc});
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        idle(3);
        chk("contention_sb_empty", sb_q.size(), 32'd0);
        last_d = rd_model(32'h0000_0100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0000_0000;
        d_wdata = 32'h0000_0000;
        d_be    = 4'h0;
        ack_en  = 1'b0;

        // Reset held with a fetch pending: everything registered stays 0.
        idle(3);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_dones", {30'd0, if_done, d_done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        idle(2);
        reset = 1'b1;
        idle(2);
        #1;
        chk("post_rst_mem_req", {31'd0, mem_req}, 32'd1);
        chk("post_rst_mem_addr", mem_addr, 32'h0000_0080);
        push(1'b0, rd_model(32'h0000_0080));
        ack_en = 1'b1;
        drain(10);
        if_req = 1'b0;
        idle(3);

        // Single fetch, ack in the first bus cycle: done 2 cycles after grant.
        ack_wait = 0;
        if_addr  = 32'h0000_0040;
        push(1'b0, 32'h2008_0005);
        @(negedge clk);
        if_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            chk("fetch_if_done", {31'd0, if_done}, {31'd0, c == 2});
            if (c == 1) begin
                chk("fetch_mem_req", {31'd0, mem_req}, 32'd1);
                chk("fetch_mem_addr", mem_addr, 32'h0000_0040);
                chk("fetch_mem_we", {31'd0, mem_we}, 32'd0);
            end
            if (c == 2) if_req = 1'b0;
        end
        chk("fetch_if_rdata", if_rdata, 32'h2008_0005);
        idle(2);

        // Write with 3 wait cycles: command stable 4 cycles, d_rdata untouched.
        ack_wait = 3;
        d_we     = 1'b1;
        d_addr   = 32'h0000_0010;
        d_wdata  = 32'hDEAD_BEEF;
        d_be     = 4'b0011;
        push(1'b1, last_d);
        @(negedge clk);
        d_req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (c >= 1 && c <= 4) begin
                chk("wr_mem_req", {31'd0, mem_req}, 32'd1);
                chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
                chk("wr_mem_addr", mem_addr, 32'h0000_0010);
                chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
                chk("wr_mem_be", {28'd0, mem_be}, 32'h0000_0003);
            end
            chk("wr_d_done", {31'd0, d_done}, {31'd0, c == 5});
            if (c == 5) begin
                chk("wr_mem_req_drop", {31'd0, mem_req}, 32'd0);
                d_req = 1'b0;
            end
        end
        d_we = 1'b0;
        idle(2);
        chk("wr_sb_empty", sb_q.size(), 32'd0);

        // Full contention pattern D,D,D,D,I,D,D,D,D,I.
        run_contention(10);

        // Reset during BUS_D with a streak of 1 already counted.
        ack_en  = 1'b0;
        d_addr  = 32'h0000_0100;
        if_addr = 32'h0000_0200;
        @(negedge clk);
        d_req  = 1'b1;
        if_req = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_mem_req_before", {31'd0, mem_req}, 32'd1);
        chk("mid_mem_addr", mem_addr, 32'h0000_0100);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_mem_req_async", {31'd0, mem_req}, 32'd0);
        d_req  = 1'b0;
        if_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk("mid_no_d_done_rst", {31'd0, d_done}, 32'd0);
        end
        reset  = 1'b1;
        ack_en = 1'b1;
        last_d = 32'h0000_0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("mid_no_d_done", {31'd0, d_done}, 32'd0);
            chk("mid_idle_mem_req", {31'd0, mem_req}, 32'd0);
        end

        // Streak restarts from 0 after reset: D,D,D,D,I.
        run_contention(5);

`ifdef ARB_TIMEOUT_EN
        // No ack at all: 15 request cycles, then a zero-data fetch done and sticky err.
        begin
            int hi;
            int n;
            hi = 0;
            n  = 0;
            ack_en  = 1'b0;
            if_addr = 32'h0000_0300;
            push(1'b0, 32'h0000_0000);
            @(negedge clk);
            if_req = 1'b1;
            while (!if_done && n < 40) begin
                @(negedge clk);
                #1;
                if (mem_req) hi = hi + 1;
                n = n + 1;
            end
            if_req = 1'b0;
            chk("to_mem_req_cycles", hi, 32'd15);
            chk("to_if_done_seen", {31'd0, if_done}, 32'd1);
            chk("to_if_rdata", if_rdata, 32'd0);
            idle(3);
            #1;
            chk("to_err_sticky", {31'd0, err}, 32'd1);
            chk("to_sb_empty", sb_q.size(), 32'd0);
            reset = 1'b0;
            #1;
            chk("to_err_reset", {31'd0, err}, 32'd0);
            reset = 1'b1;
        end
`else
        chk("err_tied_low", {31'd0, err}, 32'd0);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
